// File: rtl/uart_io_pkg.sv
// Shared constants and drain FSM encoding for the CPU-to-monitor UART output bridge.
// The CR_PEND state exists only when UART_IO_CRLF_EN is defined.
package uart_io_pkg;

    localparam int UIO_TXDATA   = 0;
    localparam int UIO_STATUS   = 1;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_MSB = 15;

    localparam logic [7:0] CHR_CR = 8'h0d;
    localparam logic [7:0] CHR_LF = 8'h0a;

`ifdef UART_IO_CRLF_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_CR_PEND = 2'd2
    } drainState_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1
    } drainState_t;
`endif

endpackage

// File: rtl/uart_io_fifo.sv
// DEPTH x 8 register FIFO with push/pop, full/empty flags, occupancy count and a
// synchronous clear. Pushes while full and pops while empty are ignored.
module uart_io_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          w_pushOk;
    logic          w_popOk;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];
    assign w_pushOk = i_push & ~o_full;
    assign w_popOk  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_pushOk && !i_clr) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_popOk) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_io_bridge.sv
// CPU IO window to monitor UART bridge: TXDATA/STATUS decode, stall on overflow, and a
// drain FSM that feeds one character per handshake. Optional LF->CRLF via UART_IO_CRLF_EN.
module uart_io_bridge
    import uart_io_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cpu_start,
    input  logic          i_io_we,
    input  logic          i_io_re,
    input  logic [AW-1:0] i_io_adr,
    input  logic [31:0]   i_io_wdata,
    output logic [31:0]   o_io_rdata,
    output logic          o_io_stall,
    output logic [7:0]    o_uart_io_char,
    output logic          o_uart_io_we,
    input  logic          i_uart_io_full
);

    localparam int CW = $clog2(DEPTH) + 1;

    drainState_t   r_state;
    drainState_t   w_stateNext;
    logic [31:0]   r_rdata;
    logic [7:0]    r_char;
    logic          r_uartWe;
    logic [7:0]    w_charNext;
    logic          w_load;
    logic          w_pop;
    logic          w_push;
    logic          w_txSel;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic [31:0]   w_status;
    logic          w_unusedWdata;

    assign w_txSel       = (i_io_adr == AW'(UIO_TXDATA));
    assign o_io_stall    = i_io_we & w_txSel & w_full;
    assign w_push        = i_io_we & w_txSel & ~i_cpu_start;
    assign w_unusedWdata = ^i_io_wdata[31:8];

    uart_io_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_cpu_start),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_io_wdata[7:0]),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                              = '0;
        w_status[STAT_FULL]                   = w_full;
        w_status[STAT_EMPTY]                  = w_empty;
        w_status[STAT_CNT_MSB:STAT_CNT_LSB]   = 8'(w_count);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_io_re) begin
            r_rdata <= (i_io_adr == AW'(UIO_STATUS)) ? w_status : '0;
        end
    end

    // Checking r_uartWe guarantees a gap cycle after every push so a registered full is seen.
    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_charNext  = r_char;
        if (i_cpu_start) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty && !i_uart_io_full && !r_uartWe) begin
                        w_load = 1'b1;
`ifdef UART_IO_CRLF_EN
                        if (w_head == CHR_LF) begin
                            w_charNext  = CHR_CR;
                            w_stateNext = ST_CR_PEND;
                        end else begin
                            w_pop       = 1'b1;
                            w_charNext  = w_head;
                            w_stateNext = ST_SEND;
                        end
`else
                        w_pop       = 1'b1;
                        w_charNext  = w_head;
                        w_stateNext = ST_SEND;
`endif
                    end
                end
                ST_SEND: begin
                    w_stateNext = ST_IDLE;
                end
`ifdef UART_IO_CRLF_EN
                ST_CR_PEND: begin
                    if (!w_empty && !i_uart_io_full && !r_uartWe) begin
                        w_load      = 1'b1;
                        w_pop       = 1'b1;
                        w_charNext  = w_head;
                        w_stateNext = ST_SEND;
                    end
                end
`endif
                default: begin
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_char   <= '0;
            r_uartWe <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_char   <= w_charNext;
            r_uartWe <= w_load;
        end
    end

    assign o_io_rdata     = r_rdata;
    assign o_uart_io_char = r_char;
    assign o_uart_io_we   = r_uartWe;

endmodule

// File: tb/tb_uart_io_bridge.sv
// Directed self-checking bench for uart_io_bridge (DEPTH=8, AW=2).
// Build with UART_IO_CRLF_EN defined or not, matching the RTL build.
module tb_uart_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuStart;
    logic        ioWe;
    logic        ioRe;
    logic [1:0]  ioAdr;
    logic [31:0] ioWdata;
    logic [31:0] ioRdata;
    logic        ioStall;
    logic [7:0]  uChar;
    logic        uWe;
    logic        uFull;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    logic [7:0] rxQ[$];
    int         rxCyc[$];

    uart_io_bridge #(.DEPTH(8), .AW(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cpu_start    (cpuStart),
        .i_io_we        (ioWe),
        .i_io_re        (ioRe),
        .i_io_adr       (ioAdr),
        .i_io_wdata     (ioWdata),
        .o_io_rdata     (ioRdata),
        .o_io_stall     (ioStall),
        .o_uart_io_char (uChar),
        .o_uart_io_we   (uWe),
        .i_uart_io_full (uFull)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Record every monitor push on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (uWe === 1'b1) begin
            rxQ.push_back(uChar);
            rxCyc.push_back(cycle);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic readReg(input logic [1:0] adr, output logic [31:0] d);
        ioRe  = 1'b1;
        ioAdr = adr;
        tick(1);
        ioRe  = 1'b0;
        d     = ioRdata;
    endtask

    task automatic writeChar(input logic [7:0] c);
        int n = 0;
        ioWe    = 1'b1;
        ioAdr   = 2'd0;
        ioWdata = {24'h0, c};
        #1;
        while (ioStall && n < 60) begin
            tick(1);
            n++;
        end
        tick(1);
        ioWe = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; cpuStart = 1'b0; ioWe = 1'b0; ioRe = 1'b0;
        ioAdr = 2'd0; ioWdata = '0; uFull = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        checks++;
        if (ioRdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h exp=%h", ioRdata, 32'h0);
        end
        checks++;
        if (uWe !== 1'b0 || uChar !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_uart got we=%b char=%h exp we=0 char=00", uWe, uChar);
        end
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL reset_status got=%h exp=%h", d, 32'h0000_0002);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        rxQ.delete(); rxCyc.delete();
        writeChar(8'h41);
        writeChar(8'h42);
        tick(10);
        checks++;
        if (rxQ.size() !== 2) begin
            failures++;
            $display("[TB] FAIL basic_count got=%0d exp=2", rxQ.size());
        end else begin
            checks++;
            if (rxQ[0] !== 8'h41 || rxQ[1] !== 8'h42) begin
                failures++;
                $display("[TB] FAIL basic_chars got=%h,%h exp=41,42", rxQ[0], rxQ[1]);
            end
            checks++;
            if (rxCyc[1] - rxCyc[0] < 2) begin
                failures++;
                $display("[TB] FAIL basic_gap got=%0d exp>=2", rxCyc[1] - rxCyc[0]);
            end
        end
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL basic_status got=%h exp=%h", d, 32'h0000_0002);
        end
        ioWe = 1'b1; ioAdr = 2'd1; ioWdata = 32'hFFFF_FF55;
        tick(1);
        ioWe = 1'b0;
        tick(4);
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0002 || rxQ.size() !== 2) begin
            failures++;
            $display("[TB] FAIL status_write_ignored got=%h rx=%0d exp=00000002 rx=2", d, rxQ.size());
        end
        readReg(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL txdata_read got=%h exp=%h", d, 32'h0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  got;
        int n = 0;
        uFull = 1'b1;
        rxQ.delete(); rxCyc.delete();
        for (int i = 0; i < 8; i++) writeChar(8'h30 + 8'(i));
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0801) begin
            failures++;
            $display("[TB] FAIL full_status got=%h exp=%h", d, 32'h0000_0801);
        end
        ioWe = 1'b1; ioAdr = 2'd0; ioWdata = 32'h0000_0038;
        #1;
        checks++;
        if (ioStall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_on_full got=%b exp=1", ioStall);
        end
        tick(4);
        checks++;
        if (ioStall !== 1'b1 || rxQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL stall_hold got stall=%b rx=%0d exp stall=1 rx=0", ioStall, rxQ.size());
        end
        uFull = 1'b0;
        while (ioStall && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (ioStall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_release got=%b exp=0", ioStall);
        end
        tick(1);
        ioWe = 1'b0;
        tick(30);
        checks++;
        if (rxQ.size() !== 9) begin
            failures++;
            $display("[TB] FAIL overflow_count got=%0d exp=9", rxQ.size());
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
            checks++;
            if (got !== 8'h30 + 8'(i)) begin
                failures++;
                $display("[TB] FAIL overflow_order[%0d] got=%h exp=%h", i, got, 8'h30 + 8'(i));
            end
        end
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL overflow_empty got=%h exp=%h", d, 32'h0000_0002);
        end
    endtask

    task automatic test_hold();
        logic [31:0] d;
        logic [7:0]  got;
        uFull = 1'b1;
        rxQ.delete(); rxCyc.delete();
        writeChar(8'h61); writeChar(8'h62); writeChar(8'h63);
        tick(20);
        checks++;
        if (rxQ.size() !== 0) begin
            failures++;
            $display("[TB] FAIL hold_no_push got=%0d exp=0", rxQ.size());
        end
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0300) begin
            failures++;
            $display("[TB] FAIL hold_status got=%h exp=%h", d, 32'h0000_0300);
        end
        uFull = 1'b0;
        tick(12);
        checks++;
        if (rxQ.size() !== 3) begin
            failures++;
            $display("[TB] FAIL hold_release_count got=%0d exp=3", rxQ.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < rxQ.size()) ? rxQ[i] : 8'hxx;
            checks++;
            if (got !== 8'h61 + 8'(i)) begin
                failures++;
                $display("[TB] FAIL hold_order[%0d] got=%h exp=%h", i, got, 8'h61 + 8'(i));
            end
        end
    endtask

    task automatic test_crlf();
        logic [31:0] d;
        logic [7:0]  g0;
        logic [7:0]  g1;
        rxQ.delete(); rxCyc.delete();
        writeChar(8'h0A);
        tick(12);
        g0 = (rxQ.size() > 0) ? rxQ[0] : 8'hxx;
        g1 = (rxQ.size() > 1) ? rxQ[1] : 8'hxx;
`ifdef UART_IO_CRLF_EN
        checks++;
        if (rxQ.size() !== 2 || g0 !== 8'h0D || g1 !== 8'h0A) begin
            failures++;
            $display("[TB] FAIL crlf got n=%0d %h,%h exp n=2 0d,0a", rxQ.size(), g0, g1);
        end
`else
        checks++;
        if (rxQ.size() !== 1 || g0 !== 8'h0A) begin
            failures++;
            $display("[TB] FAIL lf_verbatim got n=%0d %h exp n=1 0a", rxQ.size(), g0);
        end
`endif
        readReg(2'd1, d);
        checks++;
        if (d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL crlf_empty got=%h exp=%h", d, 32'h0000_0002);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        int n = 0;
        uFull = 1'b1;
        for (int i = 0; i < 5; i++) writeChar(8'h70 + 8'(i));
        rxQ.delete(); rxCyc.delete();
        uFull = 1'b0;
        while (uWe !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        checks++;
        if (uWe !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_first_push got=%b exp=1", uWe);
        end
        cpuStart = 1'b1;
        tick(1);
        cpuStart = 1'b0;
        tick(10);
        readReg(2'd1, d);
        checks++;
        if (rxQ.size() !== 1 || d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL start_flush got rx=%0d status=%h exp rx=1 status=00000002", rxQ.size(), d);
        end
        cpuStart = 1'b1;
        ioWe = 1'b1; ioAdr = 2'd0; ioWdata = 32'h0000_005A;
        tick(1);
        cpuStart = 1'b0; ioWe = 1'b0;
        tick(5);
        readReg(2'd1, d);
        checks++;
        if (rxQ.size() !== 1 || d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL start_discard_write got rx=%0d status=%h exp rx=1 status=00000002", rxQ.size(), d);
        end

        uFull = 1'b1;
        for (int i = 0; i < 5; i++) writeChar(8'h50 + 8'(i));
        rxQ.delete(); rxCyc.delete();
        uFull = 1'b0;
        n = 0;
        while (uWe !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        rst = 1'b1;
        #2;
        checks++;
        if (uWe !== 1'b0 || uChar !== 8'h00) begin
            failures++;
            $display("[TB] FAIL rst_async got we=%b char=%h exp we=0 char=00", uWe, uChar);
        end
        tick(1);
        rst = 1'b0;
        tick(10);
        readReg(2'd1, d);
        checks++;
        if (rxQ.size() > 1 || d !== 32'h0000_0002) begin
            failures++;
            $display("[TB] FAIL rst_flush got rx=%0d status=%h exp rx<=1 status=00000002", rxQ.size(), d);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_hold();
        test_crlf();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
